// File: rtl/spike_buf_pkg.sv
// Shared types and default sizing for the ping-pong spike-train buffer.
package spike_buf_pkg;

  localparam int unsigned DEF_TIMESTEPS  = 16;
  localparam int unsigned DEF_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    FULL  = 2'd1,
    CLEAR = 2'd2
  } bank_state_t;

endpackage

// File: rtl/spike_bank_ram.sv
// One bank of spike-train storage: 1W/1R synchronous RAM with a registered read port.
// Only the read register is reset; the array contents are left as-is.
module spike_bank_ram
  import spike_buf_pkg::*;
#(
  parameter int unsigned TIMESTEPS  = DEF_TIMESTEPS,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [TIMESTEPS-1:0]  i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [TIMESTEPS-1:0]  o_rdata
);

  logic [TIMESTEPS-1:0] r_mem [2**ADDR_WIDTH];
  logic [TIMESTEPS-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/spike_fibre_buffer.sv
// Ping-pong spike-train buffer feeding the TPPE fibre_a port; banks change hands by commit/release.
// Optional macro SPIKE_BUF_CLEAR_ON_RELEASE_EN zero-sweeps released banks before they are refilled.
module spike_fibre_buffer
  import spike_buf_pkg::*;
#(
  parameter int unsigned TIMESTEPS  = DEF_TIMESTEPS,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [TIMESTEPS-1:0]  wr_data,
  input  logic                  wr_commit,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] fibre_a_addr,
  input  logic                  fibre_a_read_en,
  output logic [TIMESTEPS-1:0]  fibre_a_data,
  output logic                  fibre_a_valid,
  output logic                  rd_bank_valid,
  input  logic                  rd_release,
  output logic                  active_rd_bank,
  output logic                  protocol_err
);

`ifdef SPIKE_BUF_CLEAR_ON_RELEASE_EN
  localparam bank_state_t REL_STATE = CLEAR;
`else
  localparam bank_state_t REL_STATE = FREE;
`endif

  bank_state_t r_state [2];
  logic        r_wr_sel, r_rd_sel, r_valid, r_rd_src, r_err;

  logic w_wr_ready, w_rbv, w_wr_acc, w_commit, w_rd_acc, w_release, w_viol;
  logic w_clr_go, w_clr_bank, w_clr_done;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic [TIMESTEPS-1:0]  w_rdata [2];

  assign w_wr_ready = (r_state[r_wr_sel] == FREE);
  assign w_rbv      = (r_state[r_rd_sel] == FULL);
  assign w_wr_acc   = wr_en && w_wr_ready;
  assign w_commit   = wr_commit && w_wr_ready;
  assign w_rd_acc   = fibre_a_read_en && w_rbv;
  assign w_release  = rd_release && w_rbv;
  assign w_viol     = ((wr_en || wr_commit) && !w_wr_ready) ||
                      ((fibre_a_read_en || rd_release) && !w_rbv);

`ifdef SPIKE_BUF_CLEAR_ON_RELEASE_EN
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic                  r_clr_active, r_clr_bank;

  // A sweep in progress keeps its bank; otherwise bank 0 has priority.
  always_comb begin
    w_clr_bank = r_clr_active ? r_clr_bank : (r_state[0] != CLEAR);
    w_clr_go   = r_clr_active || (r_state[0] == CLEAR) || (r_state[1] == CLEAR);
    w_clr_done = w_clr_go && (r_clr_cnt == '1);
    w_clr_addr = r_clr_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_cnt    <= '0;
      r_clr_active <= 1'b0;
      r_clr_bank   <= 1'b0;
    end else if (w_clr_go) begin
      r_clr_cnt    <= r_clr_cnt + ADDR_WIDTH'(1);
      r_clr_active <= !w_clr_done;
      r_clr_bank   <= w_clr_bank;
    end
  end
`else
  always_comb begin
    w_clr_bank = 1'b0;
    w_clr_go   = 1'b0;
    w_clr_done = 1'b0;
    w_clr_addr = '0;
  end
`endif

  // Commit, release and sweep completion always hit distinct banks, so the
  // per-element updates below never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state[0] <= REL_STATE;
      r_state[1] <= REL_STATE;
      r_wr_sel   <= 1'b0;
      r_rd_sel   <= 1'b0;
      r_valid    <= 1'b0;
      r_rd_src   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err   <= r_err || w_viol;
      r_valid <= w_rd_acc;
      if (w_rd_acc) r_rd_src <= r_rd_sel;
      if (w_commit) begin
        r_state[r_wr_sel] <= FULL;
        r_wr_sel          <= ~r_wr_sel;
      end
      if (w_release) begin
        r_state[r_rd_sel] <= REL_STATE;
        r_rd_sel          <= ~r_rd_sel;
      end
      if (w_clr_done) r_state[w_clr_bank] <= FREE;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    logic w_clr_here, w_we;
    assign w_clr_here = w_clr_go && (w_clr_bank == 1'(g));
    assign w_we       = w_clr_here || (w_wr_acc && (r_wr_sel == 1'(g)));

    spike_bank_ram #(
      .TIMESTEPS (TIMESTEPS),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
      .clk    (clk),
      .rst    (rst),
      .i_we   (w_we),
      .i_waddr(w_clr_here ? w_clr_addr : wr_addr),
      .i_wdata(w_clr_here ? '0 : wr_data),
      .i_re   (w_rd_acc && (r_rd_sel == 1'(g))),
      .i_raddr(fibre_a_addr),
      .o_rdata(w_rdata[g])
    );
  end

  assign wr_ready       = w_wr_ready;
  assign rd_bank_valid  = w_rbv;
  assign fibre_a_valid  = r_valid;
  assign fibre_a_data   = w_rdata[r_rd_src];
  assign active_rd_bank = r_rd_sel;
  assign protocol_err   = r_err;

endmodule

// File: tb/tb_spike_fibre_buffer.sv
// Randomized + directed bench for spike_fibre_buffer against a bank-level reference model.
// Honours SPIKE_BUF_CLEAR_ON_RELEASE_EN (ADDR_WIDTH drops to 4 in that build).
module tb_spike_fibre_buffer;

`ifdef SPIKE_BUF_CLEAR_ON_RELEASE_EN
  localparam int AW = 4;
  localparam bit CLR_MODE = 1'b1;
`else
  localparam int AW = 8;
  localparam bit CLR_MODE = 1'b0;
`endif
  localparam int N = 1 << AW;
  localparam int S_FREE = 0, S_FULL = 1, S_CLEAR = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en, wr_commit, fibre_a_read_en, rd_release;
  logic [AW-1:0] wr_addr, fibre_a_addr;
  logic [15:0]   wr_data;
  logic          wr_ready, fibre_a_valid, rd_bank_valid, active_rd_bank, protocol_err;
  logic [15:0]   fibre_a_data;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: per-bank ownership state, contents and remaining sweep length.
  int          m_state [2];
  int          m_left  [2];
  int          m_cur;
  bit          m_wsel, m_rsel, m_valid, m_err, m_dknown;
  logic [15:0] m_data;
  logic [15:0] m_mem   [2][N];
  bit          m_known [2][N];

  spike_fibre_buffer #(
    .TIMESTEPS (16),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_commit      (wr_commit),
    .wr_ready       (wr_ready),
    .fibre_a_addr   (fibre_a_addr),
    .fibre_a_read_en(fibre_a_read_en),
    .fibre_a_data   (fibre_a_data),
    .fibre_a_valid  (fibre_a_valid),
    .rd_bank_valid  (rd_bank_valid),
    .rd_release     (rd_release),
    .active_rd_bank (active_rd_bank),
    .protocol_err   (protocol_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_state[b] = CLR_MODE ? S_CLEAR : S_FREE;
      m_left[b]  = N;
    end
    m_cur = -1;
    m_wsel = 1'b0; m_rsel = 1'b0; m_valid = 1'b0; m_err = 1'b0;
    m_data = 16'h0; m_dknown = 1'b1;
  endtask

  task automatic model_edge(input bit we, input logic [AW-1:0] wa, input logic [15:0] wd,
                            input bit wc, input bit re, input logic [AW-1:0] ra, input bit rr);
    bit wrdy, rbv;
    wrdy = (m_state[m_wsel] == S_FREE);
    rbv  = (m_state[m_rsel] == S_FULL);
    if (((we || wc) && !wrdy) || ((re || rr) && !rbv)) m_err = 1'b1;
    m_valid = re && rbv;
    if (m_valid) begin
      m_data   = m_mem[m_rsel][ra];
      m_dknown = m_known[m_rsel][ra];
    end
    if (m_cur < 0) begin
      if (m_state[0] == S_CLEAR)      m_cur = 0;
      else if (m_state[1] == S_CLEAR) m_cur = 1;
    end
    if (m_cur >= 0) begin
      m_left[m_cur]--;
      if (m_left[m_cur] == 0) begin
        for (int i = 0; i < N; i++) begin
          m_mem[m_cur][i]   = 16'h0;
          m_known[m_cur][i] = 1'b1;
        end
        m_state[m_cur] = S_FREE;
        m_cur = -1;
      end
    end
    if (we && wrdy) begin
      m_mem[m_wsel][wa]   = wd;
      m_known[m_wsel][wa] = 1'b1;
    end
    if (wc && wrdy) begin
      m_state[m_wsel] = S_FULL;
      m_wsel = ~m_wsel;
    end
    if (rr && rbv) begin
      m_state[m_rsel] = CLR_MODE ? S_CLEAR : S_FREE;
      m_left[m_rsel]  = N;
      m_rsel = ~m_rsel;
    end
  endtask

  task automatic compare();
    chk("wr_ready", wr_ready, m_state[m_wsel] == S_FREE);
    chk("rd_bank_valid", rd_bank_valid, m_state[m_rsel] == S_FULL);
    chk("active_rd_bank", active_rd_bank, m_rsel);
    chk("fibre_a_valid", fibre_a_valid, m_valid);
    chk("protocol_err", protocol_err, m_err);
    if (m_valid && m_dknown) chk("fibre_a_data", fibre_a_data, m_data);
  endtask

  task automatic step(input bit we, input logic [AW-1:0] wa, input logic [15:0] wd,
                      input bit wc, input bit re, input logic [AW-1:0] ra, input bit rr);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_commit = wc;
    fibre_a_read_en = re; fibre_a_addr = ra; rd_release = rr;
    @(posedge clk);
    model_edge(we, wa, wd, wc, re, ra, rr);
    #1;
    wr_en = 1'b0; wr_commit = 1'b0; fibre_a_read_en = 1'b0; rd_release = 1'b0;
    compare();
  endtask

  task automatic idle();
    step(1'b0, '0, 16'h0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic wait_wr_ready(input int budget);
    int k;
    k = 0;
    while (wr_ready !== 1'b1 && k < budget) begin
      idle();
      k++;
    end
    if (wr_ready !== 1'b1) chk("wait_wr_ready", 32'(wr_ready), 32'd1);
  endtask

  task automatic do_reset();
    wr_en = 1'b0; wr_commit = 1'b0; fibre_a_read_en = 1'b0; rd_release = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    compare();
    chk("rst_data", fibre_a_data, 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    compare();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a_last, wa, ra;
    bit wrdy, rbv;
    int cnt;
    a_last = '1;
    wr_addr = '0; fibre_a_addr = '0; wr_data = 16'h0;
    do_reset();

    // Write two entries, commit, read both back.
    wait_wr_ready(N + 4);
    step(1'b1, AW'(3), 16'hA5A5, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, a_last, 16'h0001, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, '0, 16'h0, 1'b1, 1'b0, '0, 1'b0);
    chk("rbv_after_commit", rd_bank_valid, 1'b1);
    step(1'b0, '0, 16'h0, 1'b0, 1'b1, AW'(3), 1'b0);
    chk("rd_a5a5", fibre_a_data, 16'hA5A5);
    step(1'b0, '0, 16'h0, 1'b0, 1'b1, a_last, 1'b0);
    chk("rd_0001", fibre_a_data, 16'h0001);

    // Fill bank 1 while reading bank 0, then release with back-to-back reads.
    wait_wr_ready(N + 4);
    for (int i = 0; i < 4; i++)
      step(1'b1, AW'(i), 16'h1000 + 16'(i), 1'b0, 1'b1, AW'(3), 1'b0);
    step(1'b0, '0, 16'h0, 1'b1, 1'b1, a_last, 1'b0);
    step(1'b0, '0, 16'h0, 1'b0, 1'b1, AW'(3), 1'b1);
    chk("rel_read_old", fibre_a_data, 16'hA5A5);
    chk("rel_active", active_rd_bank, 1'b1);
    step(1'b0, '0, 16'h0, 1'b0, 1'b1, AW'(2), 1'b0);
    chk("nobubble_valid", fibre_a_valid, 1'b1);
    chk("nobubble_data", fibre_a_data, 16'h1002);

    // Commit and release in one cycle.
    wait_wr_ready(N + 4);
    step(1'b1, AW'(5), 16'h5555, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, '0, 16'h0, 1'b1, 1'b0, '0, 1'b1);
    chk("cr_err", protocol_err, 1'b0);
    chk("cr_rbv", rd_bank_valid, 1'b1);
    chk("cr_active", active_rd_bank, 1'b0);

    // Protocol violations: write with both banks FULL, read with none FULL.
    wait_wr_ready(N + 4);
    step(1'b1, AW'(3), 16'h3333, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, '0, 16'h0, 1'b1, 1'b0, '0, 1'b0);
    chk("full_wr_ready", wr_ready, 1'b0);
    step(1'b1, AW'(5), 16'hDEAD, 1'b0, 1'b0, '0, 1'b0);
    chk("ill_wr_err", protocol_err, 1'b1);
    step(1'b0, '0, 16'h0, 1'b0, 1'b1, AW'(5), 1'b0);
    chk("ill_wr_kept", fibre_a_data, 16'h5555);
    step(1'b0, '0, 16'h0, 1'b0, 1'b0, '0, 1'b1);
    step(1'b0, '0, 16'h0, 1'b0, 1'b0, '0, 1'b1);
    step(1'b0, '0, 16'h0, 1'b0, 1'b1, AW'(5), 1'b0);
    chk("ill_rd_valid", fibre_a_valid, 1'b0);

    // Reset right after a read request has been taken.
    wait_wr_ready(N + 4);
    step(1'b1, AW'(0), 16'hBEEF, 1'b1, 1'b0, '0, 1'b0);
    fibre_a_read_en = 1'b1; fibre_a_addr = '0;
    @(posedge clk);
    model_edge(1'b0, '0, 16'h0, 1'b0, 1'b1, '0, 1'b0);
    #1;
    chk("pre_rst_valid", fibre_a_valid, 1'b1);
    do_reset();
    chk("post_rst_valid", fibre_a_valid, 1'b0);

`ifdef SPIKE_BUF_CLEAR_ON_RELEASE_EN
    // Released bank is swept to zero in exactly N cycles.
    wait_wr_ready(2 * N + 4);
    for (int i = 0; i < N; i++) step(1'b1, AW'(i), 16'hFFFF, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, '0, 16'h0, 1'b1, 1'b0, '0, 1'b0);
    wait_wr_ready(2 * N + 4);
    step(1'b0, '0, 16'h0, 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, '0, 16'h0, 1'b0, 1'b0, '0, 1'b1);
    cnt = 0;
    while (wr_ready !== 1'b1 && cnt < 4 * N) begin
      idle();
      cnt++;
    end
    chk("clear_cycles", cnt, N);
    step(1'b0, '0, 16'h0, 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, '0, 16'h0, 1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < N; i++) begin
      step(1'b0, '0, 16'h0, 1'b0, 1'b1, AW'(i), 1'b0);
      chk("cleared_zero", fibre_a_data, 16'h0);
    end
`else
    cnt = 0;
`endif

    // Random legal traffic.
    for (int c = 0; c < 3000; c++) begin
      wrdy = (m_state[m_wsel] == S_FREE);
      rbv  = (m_state[m_rsel] == S_FULL);
      wa = ($urandom_range(0, 3) == 0) ? a_last : AW'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? a_last : AW'($urandom_range(0, 15));
      step(wrdy && ($urandom_range(0, 1) == 1), wa, 16'($urandom),
           wrdy && ($urandom_range(0, 7) == 0),
           rbv && ($urandom_range(0, 1) == 1), ra,
           rbv && ($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spike_fibre_buffer.md
# spike_fibre_buffer

Ping-pong spike-train store that feeds the fibre_a memory interface of the TPPE. The upstream LIF stage writes per-neuron TIMESTEPS-bit spike trains into the fill bank while the TPPE reads the previously committed bank through `fibre_a_addr`/`fibre_a_read_en`. Read data returns with one-cycle latency. Bank ownership moves by a commit/release handshake, so the fill of layer N+1 overlaps the TPPE consumption of layer N.

## Interface
- `TIMESTEPS`, 16: width of one spike train (one entry).
- `ADDR_WIDTH`, 8: entry address width; each bank holds 2**ADDR_WIDTH entries.
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `wr_en`  in  1: write `wr_data` to `wr_addr` of the fill bank.
- `wr_addr`  in  ADDR_WIDTH: write address.
- `wr_data`  in  TIMESTEPS: spike train to store.
- `wr_commit`  in  1: pulse; the fill bank is complete.
- `wr_ready`  out  1: the fill bank is FREE and accepts writes and commit.
- `fibre_a_addr`  in  ADDR_WIDTH: read address from the TPPE.
- `fibre_a_read_en`  in  1: read request.
- `fibre_a_data`  out  TIMESTEPS: registered read data.
- `fibre_a_valid`  out  1: `fibre_a_data` is valid this cycle.
- `rd_bank_valid`  out  1: the read bank is FULL and reads are legal.
- `rd_release`  in  1: pulse; the TPPE is finished with the read bank.
- `active_rd_bank`  out  1: index of the current read bank (`rd_sel`).
- `protocol_err`  out  1: sticky flag for a protocol violation. It clears only on reset.

## Operation
- Each bank has one state: FREE, FULL, or CLEAR (CLEAR exists only under the macro).
- Two 1-bit pointers select the banks: `wr_sel` and `rd_sel`.
- Bank states are driven as follows:
  - `wr_ready` = (state[`wr_sel`] == FREE).
  - `rd_bank_valid` = (state[`rd_sel`] == FULL).
- Write: `wr_en` && `wr_ready` stores the entry in the `wr_sel` bank.
- Commit: `wr_commit` && `wr_ready` sets state[`wr_sel`] to FULL and toggles `wr_sel`.
  - A write in the same cycle as the commit is stored before the commit takes effect.
- Read: `fibre_a_read_en` && `rd_bank_valid` makes the next cycle return `fibre_a_valid`=1 with the data from bank `rd_sel`.
- Release: `rd_release` && `rd_bank_valid` sets state[`rd_sel`] to FREE (CLEAR under the macro) and toggles `rd_sel`.
  - A read issued in the release cycle is still served from the old bank.
- A commit and a release in the same cycle both take effect. They always target different banks, because one bank is FREE and the other FULL.
- Any of the following sets `protocol_err`, and the offending request is otherwise ignored:
  - `wr_en` or `wr_commit` while `wr_ready`=0;
  - `fibre_a_read_en` or `rd_release` while `rd_bank_valid`=0.
- An ignored read produces no valid pulse.
- Read-after-write to the same entry cannot occur, since each bank has a single owner.
- Reset values:
  - `wr_sel`=`rd_sel`=0 and both banks FREE (CLEAR under the macro);
  - `fibre_a_valid`=0, `fibre_a_data`=0, `protocol_err`=0, `active_rd_bank`=0.
- Reset mid-read drops the pending valid.
- Memory contents are not reset.

## Timing
- Read latency is exactly 1 cycle. Back-to-back reads sustain one result per cycle.
- `wr_ready` and `rd_bank_valid` are decoded combinationally from the registered state; there is no combinational input-to-output path.
- Commit to `rd_bank_valid`: the cycle after commit, if `rd_sel` points at the committed bank.
- Release to `wr_ready`: the cycle after release, if `wr_sel` points at the released bank. Without the macro the released bank goes straight to FREE.
- Steady state: the fill of the next layer overlaps the reads of the current one with no bubble.

## Configuration
- `SPIKE_BUF_CLEAR_ON_RELEASE_EN` defined:
  - A released bank enters CLEAR.
  - A shared counter writes zero to entries 0..2**ADDR_WIDTH-1, one entry per cycle, and the bank then becomes FREE.
  - Reset puts both banks in CLEAR. They are swept bank 0 first, then bank 1.
  - `wr_ready` stays low for the bank being cleared.
  - Unwritten entries therefore read 0, i.e. silent neurons.
- Undefined:
  - Release goes straight to FREE.
  - Stale data persists in the bank.
  - No clear counter is built.

## Structure
- Package `spike_buf_pkg` holds:
  - the `bank_state_t` enum (FREE, FULL, CLEAR);
  - the default TIMESTEPS and ADDR_WIDTH localparams.
- Sub-module `spike_bank_ram` is a single-bank, one-write/one-read synchronous RAM (2**ADDR_WIDTH x TIMESTEPS) with registered read. It is instantiated twice.
- The top level holds the pointers, bank states, error logic, output mux and clear counter.

## Test plan
- Write 0xA5A5 to addr 3 and 0x0001 to addr 255, then commit, then read addr 3 and addr 255 → `rd_bank_valid`=1 the cycle after commit, and `fibre_a_data` returns 0xA5A5 then 0x0001, each one cycle after its request.
- Fill bank 1 while reading bank 0, then release bank 0 → `active_rd_bank` goes 0→1 and reads return bank 1 data with no bubble.
- Commit and release in the same cycle → both take effect, `protocol_err` stays 0, and `wr_ready` and `rd_bank_valid` are correct on the next cycle.
- Write with `wr_ready`=0 (both banks FULL), and read with `rd_bank_valid`=0 → `protocol_err` goes 1, the stored data is unchanged, and no `fibre_a_valid` pulse occurs.
- Assert `rst` on the cycle after a read request → `fibre_a_valid` is 0 immediately and all outputs return to their reset values.
- With `SPIKE_BUF_CLEAR_ON_RELEASE_EN` and ADDR_WIDTH=4:
  - Release a bank written with 0xFFFF, then commit it again without writing.
  - Expected: `wr_ready` returns exactly 16 cycles after the release, and every read of the recommitted bank returns 0.
